// File: rtl/ysyx_24100012_lsu_pkg.sv
// ============================================================================
// Module   : ysyx_24100012_lsu_pkg
// Brief    : Shared constants for the LSU control stage. Holds the RV32I
//            load/store func3 codes, the FSM state encoding and small helpers
//            for access-size decode and address alignment.
// Ports    : none (package)
// Config   : the helpers serve both builds; LSU_MISALIGN_TRAP_EN selects
//            which of them the top module uses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_24100012_lsu_pkg;

  // Load func3 codes
  localparam logic [2:0] C_F3_LB  = 3'b000;
  localparam logic [2:0] C_F3_LH  = 3'b001;
  localparam logic [2:0] C_F3_LW  = 3'b010;
  localparam logic [2:0] C_F3_LBU = 3'b100;
  localparam logic [2:0] C_F3_LHU = 3'b101;

  // Store func3 codes
  localparam logic [2:0] C_F3_SB  = 3'b000;
  localparam logic [2:0] C_F3_SH  = 3'b001;
  localparam logic [2:0] C_F3_SW  = 3'b010;

  // FSM state encoding
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_WAIT = 2'd2;
  localparam logic [1:0] C_ST_DONE = 2'd3;

  // Halfword access? Store and load encodings differ (LHU has no store twin).
  function automatic logic is_half(input logic is_store, input logic [2:0] f3);
    return is_store ? (f3 == C_F3_SH) : ((f3 == C_F3_LH) || (f3 == C_F3_LHU));
  endfunction

  function automatic logic is_word(input logic is_store, input logic [2:0] f3);
    return is_store ? (f3 == C_F3_SW) : (f3 == C_F3_LW);
  endfunction

  function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] lo);
    return (is_half(is_store, f3) && lo[0]) ||
           (is_word(is_store, f3) && (lo != 2'b00));
  endfunction

  // Clear the address bits that the access size ignores.
  function automatic logic [1:0] force_align(input logic is_store, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [1:0] r;
    r = lo;
    if (is_word(is_store, f3))      r = 2'b00;
    else if (is_half(is_store, f3)) r = {lo[1], 1'b0};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24100012_lsu_align.sv
// ============================================================================
// Module   : ysyx_24100012_lsu_align
// Brief    : Combinational lane logic for the LSU: byte strobes and lane
//            replication for stores, byte/half extraction plus sign/zero
//            extension for loads.
// Ports    : func3_i    access func3
//            off_i      byte offset within the word (addr[1:0])
//            st_data_i  raw store data (rs2)
//            ld_word_i  raw aligned word from memory
//            wstrb_o    store byte strobes
//            st_data_o  lane-replicated store data
//            ld_data_o  extracted and extended load data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24100012_lsu_align
  import ysyx_24100012_lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte uses the full offset; halfword only the upper offset bit.
  assign w_byte = ld_word_i[{off_i, 3'b000} +: 8];
  assign w_half = ld_word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    wstrb_o   = 4'b1111;
    st_data_o = st_data_i;
    case (func3_i)
      C_F3_SB: begin
        wstrb_o   = 4'b0001 << off_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      C_F3_SH: begin
        wstrb_o   = 4'b0011 << {off_i[1], 1'b0};
        st_data_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data_o = ld_word_i;
    case (func3_i)
      C_F3_LB:  ld_data_o = {{24{w_byte[7]}}, w_byte};
      C_F3_LH:  ld_data_o = {{16{w_half[15]}}, w_half};
      C_F3_LBU: ld_data_o = {24'd0, w_byte};
      C_F3_LHU: ld_data_o = {16'd0, w_half};
      default:  ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_24100012_lsu_ctrl.sv
// ============================================================================
// Module   : ysyx_24100012_lsu_ctrl
// Brief    : Multi-cycle load/store control between EXU and data memory.
//            One access in flight: IDLE -> REQ -> WAIT -> DONE -> IDLE.
// Ports    : clk_i, rst_ni                 clock, async active-low reset
//            in_*_i / in_ready_o           access from EXU (accepted in IDLE)
//            mem_req_*_o / mem_req_ready_i word-aligned memory request
//            mem_resp_valid_i, _rdata_i    memory response (WAIT only)
//            out_*_o / out_ready_i         result to WBU (held in DONE)
// Config   : LSU_MISALIGN_TRAP_EN - misaligned H/W accesses skip memory and
//            complete with out_err_o=1; otherwise low address bits are
//            forced aligned and out_err_o is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24100012_lsu_ctrl
  import ysyx_24100012_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_is_store_i,
  input  logic [2:0]            in_func3_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [DATA_WIDTH-1:0] in_wdata_i,
  input  logic [4:0]            in_rd_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
  output logic [3:0]            mem_req_wstrb_o,
  input  logic                  mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_rdata_o,
  output logic [4:0]            out_rd_o,
  output logic                  out_is_store_o,
  output logic                  out_err_o
);

  logic [1:0]            state_q, state_d;
  logic                  is_store_q;
  logic [2:0]            func3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  w_accept;
  logic                  w_trap;
  logic [1:0]            w_lo;
  logic [3:0]            w_wstrb;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_accept = (state_q == C_ST_IDLE) && in_valid_i;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign w_trap = misaligned(in_is_store_i, in_func3_i, in_addr_i[1:0]);
  assign w_lo   = in_addr_i[1:0];
`else
  assign w_trap = 1'b0;
  assign w_lo   = force_align(in_is_store_i, in_func3_i, in_addr_i[1:0]);
`endif

  // Lane logic works purely from captured registers so the request stays
  // stable while the memory stalls.
  ysyx_24100012_lsu_align u_align (
    .func3_i   (func3_q),
    .off_i     (addr_q[1:0]),
    .st_data_i (wdata_q),
    .ld_word_i (mem_resp_rdata_i),
    .wstrb_o   (w_wstrb),
    .st_data_o (w_st_data),
    .ld_data_o (w_ld_data)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= C_ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE: if (in_valid_i)       state_d = w_trap ? C_ST_DONE : C_ST_REQ;
      C_ST_REQ:  if (mem_req_ready_i)  state_d = C_ST_WAIT;
      C_ST_WAIT: if (mem_resp_valid_i) state_d = C_ST_DONE;
      C_ST_DONE: if (out_ready_i)      state_d = C_ST_IDLE;
      default:                         state_d = C_ST_IDLE;
    endcase
  end

  // Capture registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_store_q <= 1'b0;
      func3_q    <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 5'd0;
      rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else if (w_accept) begin
      is_store_q <= in_is_store_i;
      func3_q    <= in_func3_i;
      addr_q     <= {in_addr_i[ADDR_WIDTH-1:2], w_lo};
      wdata_q    <= in_wdata_i;
      rd_q       <= in_rd_i;
      rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q      <= w_trap;
`endif
    end else if ((state_q == C_ST_WAIT) && mem_resp_valid_i) begin
      rdata_q <= is_store_q ? '0 : w_ld_data;
    end
  end

  // Outputs; request fields are zero outside REQ
  always_comb begin
    in_ready_o      = (state_q == C_ST_IDLE);
    mem_req_valid_o = (state_q == C_ST_REQ);
    out_valid_o     = (state_q == C_ST_DONE);
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    mem_req_wstrb_o = 4'b0000;
    if (state_q == C_ST_REQ) begin
      mem_req_we_o    = is_store_q;
      mem_req_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      mem_req_wdata_o = w_st_data;
      mem_req_wstrb_o = is_store_q ? w_wstrb : 4'b0000;
    end
    out_rdata_o    = rdata_q;
    out_rd_o       = rd_q;
    out_is_store_o = is_store_q;
`ifdef LSU_MISALIGN_TRAP_EN
    out_err_o      = err_q;
`else
    out_err_o      = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100012_lsu_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_24100012_lsu_ctrl
// Brief    : Directed self-checking bench for ysyx_24100012_lsu_ctrl with
//            hand-computed expected values. Handles both builds of
//            LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_24100012_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_store;
  logic [2:0]  in_func3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_is_store, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24100012_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_is_store_i    (in_is_store),
    .in_func3_i       (in_func3),
    .in_addr_i        (in_addr),
    .in_wdata_i       (in_wdata),
    .in_rd_i          (in_rd),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_we_o     (mem_req_we),
    .mem_req_addr_o   (mem_req_addr),
    .mem_req_wdata_o  (mem_req_wdata),
    .mem_req_wstrb_o  (mem_req_wstrb),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_rdata_i (mem_resp_rdata),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_rdata_o      (out_rdata),
    .out_rd_o         (out_rd),
    .out_is_store_o   (out_is_store),
    .out_err_o        (out_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access; called with the DUT idle, just after a rising edge.
  task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                            input logic [31:0] rdata, input int req_stall, input int out_stall,
                            input bit poke, input logic [31:0] e_addr, input logic [3:0] e_strb,
                            input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_is_store = st; in_func3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
    tick();
    // Scramble inputs: the request must come from captured state only.
    in_valid = 1'b0; in_is_store = ~st; in_func3 = ~f3; in_addr = 32'hDEAD_BEEF;
    in_wdata = 32'h5A5A_A5A5; in_rd = ~rd;
    for (int i = 0; i <= req_stall; i++) begin
      check_eq({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
      check_eq({tag, ".req_addr"},  mem_req_addr, e_addr);
      check_eq({tag, ".req_we"},    {31'd0, mem_req_we}, {31'd0, st});
      check_eq({tag, ".req_wstrb"}, {28'd0, mem_req_wstrb}, {28'd0, e_strb});
      check_eq({tag, ".req_wdata"}, mem_req_wdata, e_wdata);
      mem_req_ready = (i == req_stall);
      tick();
    end
    mem_req_ready = 1'b0;
    check_eq({tag, ".wait_req"}, {31'd0, mem_req_valid}, 32'd0);
    check_eq({tag, ".wait_out"}, {31'd0, out_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i <= out_stall; i++) begin
      check_eq({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, ".out_rdata"}, out_rdata, e_rdata);
      check_eq({tag, ".out_rd"},    {27'd0, out_rd}, {27'd0, rd});
      check_eq({tag, ".out_st"},    {31'd0, out_is_store}, {31'd0, st});
      check_eq({tag, ".out_err"},   {31'd0, out_err}, 32'd0);
      check_eq({tag, ".busy_rdy"},  {31'd0, in_ready}, 32'd0);
      out_ready = (i == out_stall);
      in_valid  = poke && (i < out_stall);
      tick();
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check_eq({tag, ".idle_out"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, ".idle_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_is_store = 1'b0; in_func3 = 3'd0; in_addr = 32'd0;
    in_wdata = 32'd0; in_rd = 5'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'd0; out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst.in_ready",  {31'd0, in_ready}, 32'd1);
    check_eq("rst.req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst.req_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
    check_eq("rst.req_addr",  mem_req_addr, 32'd0);
    check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst.out_rdata", out_rdata, 32'd0);
    check_eq("rst.out_err",   {31'd0, out_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: LB a=0x103 -> byte 0x80 sign-extended
    run_access("lb", 1'b0, 3'b000, 32'h103, 32'd0, 5'd3, 32'h80AA_BBCC, 0, 0, 1'b0,
               32'h100, 4'b0000, 32'd0, 32'hFFFF_FF80);
    // 2: SH a=0x202
    run_access("sh", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd4, 32'hFFFF_FFFF, 0, 0, 1'b0,
               32'h200, 4'b1100, 32'hABCD_ABCD, 32'd0);
    // 3: LHU a=0x2 with request and output stalls
    run_access("lhu", 1'b0, 3'b101, 32'h2, 32'd0, 5'd5, 32'h9ABC_0000, 3, 2, 1'b0,
               32'h0, 4'b0000, 32'd0, 32'h0000_9ABC);
    // Further lane patterns
    run_access("sb", 1'b1, 3'b000, 32'h101, 32'hCAFE_0055, 5'd6, 32'h0, 0, 0, 1'b0,
               32'h100, 4'b0010, 32'h5555_5555, 32'd0);
    run_access("sw", 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 5'd7, 32'h0, 1, 0, 1'b0,
               32'h8, 4'b1111, 32'hDEAD_BEEF, 32'd0);
    run_access("lh", 1'b0, 3'b001, 32'h2, 32'd0, 5'd8, 32'h8001_0000, 0, 0, 1'b0,
               32'h0, 4'b0000, 32'd0, 32'hFFFF_8001);
    run_access("lbu", 1'b0, 3'b100, 32'h1, 32'd0, 5'd9, 32'h0000_FF00, 0, 0, 1'b0,
               32'h0, 4'b0000, 32'd0, 32'h0000_00FF);

    // 4: misaligned LW a=0x6
`ifdef LSU_MISALIGN_TRAP_EN
    in_valid = 1'b1; in_is_store = 1'b0; in_func3 = 3'b010; in_addr = 32'h6; in_rd = 5'd10;
    tick();
    in_valid = 1'b0;
    check_eq("trap.req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("trap.out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("trap.out_err",   {31'd0, out_err}, 32'd1);
    check_eq("trap.out_rdata", out_rdata, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("trap.idle", {31'd0, in_ready}, 32'd1);
`else
    run_access("lw_mis", 1'b0, 3'b010, 32'h6, 32'd0, 5'd10, 32'hA5A5_0F0F, 0, 0, 1'b0,
               32'h4, 4'b0000, 32'd0, 32'hA5A5_0F0F);
    run_access("lh_mis", 1'b0, 3'b001, 32'h3, 32'd0, 5'd11, 32'h1234_5678, 0, 0, 1'b0,
               32'h0, 4'b0000, 32'd0, 32'h0000_1234);
`endif

    // 5: reset while in WAIT, late response ignored, then a clean LW
    in_valid = 1'b1; in_is_store = 1'b0; in_func3 = 3'b010; in_addr = 32'h10; in_rd = 5'd12;
    tick();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_eq("rstw.in_wait", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstw.in_ready",  {31'd0, in_ready}, 32'd1);
    check_eq("rstw.out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    check_eq("late.in_ready",  {31'd0, in_ready}, 32'd1);
    check_eq("late.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("late.out_rdata", out_rdata, 32'd0);
    run_access("lw_post", 1'b0, 3'b010, 32'h8, 32'd0, 5'd13, 32'h1122_3344, 0, 0, 1'b0,
               32'h8, 4'b0000, 32'd0, 32'h1122_3344);

    // 6: stray response in IDLE, then in_valid poked while in DONE
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    mem_resp_valid = 1'b0;
    check_eq("stray.in_ready",  {31'd0, in_ready}, 32'd1);
    check_eq("stray.req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("stray.out_valid", {31'd0, out_valid}, 32'd0);
    run_access("poke", 1'b0, 3'b000, 32'h2, 32'd0, 5'd14, 32'h0042_0000, 0, 2, 1'b1,
               32'h0, 4'b0000, 32'd0, 32'h0000_0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
